// File: rtl/adder_arbiter_pkg.sv
// Shared types and defaults for the adder arbiter slice.
//   DEFAULT_*  : default parameter values used by adder_arbiter
//   ADD_W      : adder result width (operand width + 1, no truncation)
//   ID_W       : requester id width for the default requester count
//   rsp_t      : one response entry {requester id, signed sum}
//   id_width() : id width for any requester count (at least 1 bit)
package adder_arbiter_pkg;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_DW        = 4;
  localparam int DEFAULT_ADD_LAT   = 1;
  localparam int DEFAULT_RSP_DEPTH = 4;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  localparam int ADD_W = DEFAULT_DW + 1;
  localparam int ID_W  = id_width(DEFAULT_N_REQ);

  typedef struct packed {
    logic [ID_W-1:0]         id;
    logic signed [ADD_W-1:0] c;
  } rsp_t;

endpackage

// File: rtl/adder_rsp_fifo.sv
// Synchronous response FIFO holding {id, sum} entries.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write strobe and entry (ignored when full)
//   pop          : read strobe (ignored when empty)
//   rdata        : head entry, all zeros while empty
//   empty, full  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// Pointers wrap modulo DEPTH, so non-power-of-two depths work.
module adder_rsp_fifo
  import adder_arbiter_pkg::*;
#(
  parameter type entry_t = rsp_t,
  parameter int  DEPTH   = DEFAULT_RSP_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  entry_t                       wdata,
  input  logic                         pop,
  output entry_t                       rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are live, and rdata is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered signed adder among N_REQ
// requesters, returning {id, sum} through a credit-controlled FIFO.
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b         : packed signed operands, slice i = requester i
//   add_en, add_a, add_b : registered issue to the shared adder
//   add_c                : adder result, valid ADD_LAT clocks after add_en
//   rsp_valid/rsp_ready  : response handshake, rsp_id/rsp_c show the head
//   busy                 : any op issued, in the adder or buffered
// Every issue consumes a credit and every pop returns one, so the number of
// ops in flight plus buffered never exceeds the FIFO depth.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int DW        = DEFAULT_DW,
  parameter int ADD_LAT   = DEFAULT_ADD_LAT,
  parameter int RSP_DEPTH = DEFAULT_RSP_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DW-1:0]           req_a,
  input  logic [N_REQ*DW-1:0]           req_b,
  output logic [DW-1:0]                 add_a,
  output logic [DW-1:0]                 add_b,
  output logic                          add_en,
  input  logic signed [DW:0]            add_c,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [id_width(N_REQ)-1:0]    rsp_id,
  output logic signed [DW:0]            rsp_c,
  output logic                          busy
);

  localparam int SUM_W  = DW + 1;
  localparam int IDW    = id_width(N_REQ);
  localparam int CRED_W = $clog2(RSP_DEPTH+1);

  typedef struct packed {
    logic [IDW-1:0]          id;
    logic signed [SUM_W-1:0] c;
  } entry_t;

  logic [IDW-1:0]              rr_ptr;
  logic [CRED_W-1:0]           credits;
  logic                        grant_vld;
  logic [IDW-1:0]              grant_id;
  logic                        issue;
  logic [IDW-1:0]              iss_id;
  logic [ADD_LAT-1:0]          tag_vld;
  logic [ADD_LAT-1:0][IDW-1:0] tag_id;
  logic                        rsp_pop;
  entry_t                      fifo_wdata;
  entry_t                      fifo_rdata;
  logic                        fifo_empty;
  logic                        fifo_full_unused;
  logic [CRED_W-1:0]           fifo_count;

  // Round-robin search: scan offsets from the highest down so the lowest
  // offset from rr_ptr with a valid request is the one left standing.
  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no latch can be inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (reset && credits != '0) begin
      for (int off = N_REQ-1; off >= 0; off--) begin
        if (req_valid[(int'(rr_ptr) + off) % N_REQ]) begin
          grant_vld = 1'b1;
          grant_id  = IDW'((int'(rr_ptr) + off) % N_REQ);
        end
      end
    end
  end

  assign issue     = grant_vld;
  assign req_ready = grant_vld ? (N_REQ'(1) << grant_id) : '0;
  assign rsp_pop   = rsp_valid && rsp_ready;

  // The registered add_en stage feeds the first tag stage, so the last tag
  // stage lines up with add_c from an adder that registers ADD_LAT times.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      credits <= CRED_W'(RSP_DEPTH);
      add_en  <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      iss_id  <= '0;
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      add_en <= issue;
      iss_id <= grant_id;
      add_a  <= issue ? req_a[int'(grant_id)*DW +: DW] : '0;
      add_b  <= issue ? req_b[int'(grant_id)*DW +: DW] : '0;
      if (issue) begin
        rr_ptr <= (int'(grant_id) == N_REQ-1) ? '0 : grant_id + IDW'(1);
      end

      tag_vld[0] <= add_en;
      tag_id[0]  <= iss_id;
      for (int s = 1; s < ADD_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end

      case ({issue, rsp_pop})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: ;
      endcase
    end
  end

  assign fifo_wdata.id = tag_id[ADD_LAT-1];
  assign fifo_wdata.c  = add_c;

  // Credits guarantee a free slot for every result leaving the tag pipe,
  // so full never gates a push in practice.
  adder_rsp_fifo #(
    .entry_t (entry_t),
    .DEPTH   (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (tag_vld[ADD_LAT-1]),
    .wdata (fifo_wdata),
    .pop   (rsp_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_rdata.id;
  assign rsp_c     = fifo_rdata.c;
  assign busy      = add_en || (|tag_vld) || (fifo_count != '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus a random
// phase, all checked every cycle against an in-order scoreboard of issued
// operations (credits = depth - outstanding ops).
module tb_adder_arbiter;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic [DW-1:0]     add_a;
  logic [DW-1:0]     add_b;
  logic              add_en;
  logic signed [DW:0] add_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic signed [DW:0] rsp_c;
  logic              busy;

  adder_arbiter #(
    .N_REQ(N), .DW(DW), .ADD_LAT(LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_c(add_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared adder: one register stage, sign-extended sum.
  always @(posedge clk) begin
    add_c <= add_en ? ({add_a[DW-1], add_a} + {add_b[DW-1], add_b}) : '0;
  end

  typedef struct {
    int id;
    int c;
    int due;
  } op_t;

  op_t q[$];
  int  rr;
  int  cyc;
  bit  prev_v;
  int  prev_a;
  int  prev_b;
  int  last_grant;
  int  total;
  int  bad;
  int  dut_hs;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sx4(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx5(input logic [DW:0] v);
    return int'($signed(v));
  endfunction

  task automatic reset_model();
    q.delete();
    rr         = 0;
    prev_v     = 1'b0;
    prev_a     = 0;
    prev_b     = 0;
    last_grant = -1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
  endtask

  // Requesters that are waiting keep valid and operands; everyone else
  // redraws valid (forced where asked) and fresh random operands.
  task automatic randomize_inputs(input int vp, input logic [N-1:0] force_m);
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && last_grant != i)) begin
        req_valid[i] = force_m[i] || (int'($urandom_range(99)) < vp);
        set_req(i, int'($urandom_range(15)), int'($urandom_range(15)));
      end
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance the
  // scoreboard across the rising edge. Returns at rising edge + 1.
  task automatic step();
    int  credits;
    int  g;
    int  ga;
    int  gb;
    bit  ev;
    bit  pop;
    op_t o;
    @(negedge clk);
    credits = DEPTH - q.size();
    g = -1;
    if (credits > 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    ga = 0;
    gb = 0;
    if (g >= 0) begin
      ga = sx4(req_a[g*DW +: DW]);
      gb = sx4(req_b[g*DW +: DW]);
    end
    check("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
    check("add_en", int'(add_en), int'(prev_v));
    check("add_a", sx4(add_a), prev_v ? prev_a : 0);
    check("add_b", sx4(add_b), prev_v ? prev_b : 0);
    ev = 1'b0;
    if (q.size() > 0) ev = (q[0].due <= cyc);
    check("rsp_valid", int'(rsp_valid), int'(ev));
    if (ev) begin
      check("rsp_id", int'(rsp_id), q[0].id);
      check("rsp_c", sx5(rsp_c), q[0].c);
    end
    check("busy", int'(busy), int'(q.size() > 0));
    if (|(req_valid & req_ready)) dut_hs++;
    pop = ev && rsp_ready;

    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      o.id  = g;
      o.c   = ga + gb;
      o.due = cyc + LAT + 1;
      q.push_back(o);
      rr = (g + 1) % N;
    end
    prev_v     = (g >= 0);
    prev_a     = ga;
    prev_b     = gb;
    last_grant = g;
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_add_en"}, int'(add_en), 0);
    check({tag, "_add_a"}, int'(add_a), 0);
    check({tag, "_add_b"}, int'(add_b), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_id"}, int'(rsp_id), 0);
    check({tag, "_rsp_c"}, sx5(rsp_c), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) step();
  endtask

  int ta[3];
  int tb_[3];

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    dut_hs = 0;
    reset = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 0: 3 + 4.
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_req(0, 3, 4);
    step();
    req_valid = '0;
    repeat (4) step();

    // All requesters valid continuously: rotating grants, no bubbles.
    req_valid = 4'hF;
    for (int n = 0; n < 12; n++) begin
      step();
      randomize_inputs(0, 4'hF);
    end
    idle(5);

    // Operand extremes through requester 3.
    ta  = '{-8, 7, -8};
    tb_ = '{-8, 7, 7};
    for (int n = 0; n < 3; n++) begin
      req_valid = 4'b1000;
      set_req(3, ta[n], tb_[n]);
      step();
      req_valid = '0;
      repeat (3) step();
    end

    // Backpressure: only the credits' worth of issues, then one per pop.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    dut_hs = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      randomize_inputs(0, 4'b0010);
    end
    check("bp_issues", dut_hs, 4);
    rsp_ready = 1'b1;
    step();
    randomize_inputs(0, 4'b0010);
    rsp_ready = 1'b0;
    dut_hs = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      randomize_inputs(0, 4'b0010);
    end
    check("bp_after_pop", dut_hs, 1);
    idle(8);

    // One credit left: a pop and an issue on the same edge keep it at one.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      step();
      randomize_inputs(0, 4'b0100);
    end
    req_valid = '0;
    repeat (4) step();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    dut_hs = 0;
    step();
    randomize_inputs(0, 4'b0100);
    step();
    check("pop_issue", dut_hs, 2);
    idle(6);

    // Reset with two ops in flight and one buffered.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int n = 0; n < 3; n++) begin
      step();
      randomize_inputs(0, 4'hF);
    end
    reset = 1'b0;
    #1;
    reset_checks("midreset");
    reset_model();
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    dut_hs = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      randomize_inputs(0, 4'hF);
    end
    check("post_reset_credits", dut_hs, 4);
    idle(8);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs(50, '0);
      rsp_ready = (int'($urandom_range(99)) < 70);
      step();
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin arbiter that shares the single signed adder among N_REQ requesters. It accepts operand pairs through per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. A tag pipeline follows each issue through the adder latency, and the result is returned with the requester id through a credit-controlled response FIFO. It sits between the requesting datapaths and the existing adder instance.

Parameters:
N_REQ, 4, number of requesters (>=2)
DW, 4, operand width, signed 2's complement
ADD_LAT, 1, adder latency in clocks (C registered)
RSP_DEPTH, 4, response FIFO depth = total credits

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant/accept
req_a  in  N_REQ*DW  packed signed operand A, slice i = requester i
req_b  in  N_REQ*DW  packed signed operand B
add_a  out  DW  operand A to shared adder
add_b  out  DW  operand B to shared adder
add_en  out  1  issue strobe to adder
add_c  in  DW+1  signed adder result, valid ADD_LAT clocks after issue
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  $clog2(N_REQ)  requester id of response
rsp_c  out  DW+1  signed sum
busy  out  1  any op in flight or buffered

Behaviour:
- Reset (reset=0, async): rr_ptr=0, credits=RSP_DEPTH, tag pipe invalid, FIFO empty; req_ready=0, add_en=0, add_a=add_b=0, rsp_valid=0, rsp_id=0, rsp_c=0, busy=0. In-flight and buffered ops are discarded.
- Issue condition: |req_valid && credits>0. The grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
- req_ready is one-hot or zero and combinational from req_valid/rr_ptr/credits. A transfer occurs when req_valid[i]&&req_ready[i]. The requester holds a/b stable while valid and not ready.
- On issue: add_en=1, add_a/add_b = granted slices (unmodified). rr_ptr <= (grant+1) mod N_REQ. With no issue, add_en=0, add_a=add_b=0, rr_ptr unchanged.
- Tag pipe: ADD_LAT-deep shift of {valid,id} loaded on issue. When the last stage is valid, add_c and id are written into the FIFO on the next clk edge.
- Request-to-rsp_valid latency is ADD_LAT+1 clocks (handshake edge k → rsp_valid high after edge k+ADD_LAT+1).
- Credits: decrement on issue, increment on FIFO pop, unchanged when both occur. Invariant: credits + in_flight + fifo_count = RSP_DEPTH. The FIFO can therefore never overflow, and an add_c result is never dropped.
- FIFO: rsp_valid = !empty. Pop on rsp_valid&&rsp_ready. rsp_c/rsp_id show the head entry and hold while rsp_ready=0. Push and pop in the same cycle are allowed. Pointers wrap modulo RSP_DEPTH.
- Widths: rsp_c is add_c passed through without truncation. Expected value is sign-extended a + sign-extended b, range -2^DW..2^DW-2.
- busy = in_flight!=0 || !empty.

Decomposition:
- Package pack:
  - ADD_W = DW+1
  - typedef rsp_t struct {id, logic signed [ADD_W-1:0] c}
  - localparam ID_W = $clog2(N_REQ) helper function.
- Sub-module adder_rsp_fifo: parameterised sync FIFO of rsp_t, depth RSP_DEPTH, with push/pop/empty/full/count, async active-low reset.
- Round-robin search, tag pipe and credit counter stay in adder_arbiter.

Test Plan:
1. Req0 only, a=3, b=4, rsp_ready=1 → single grant, add_en one cycle, rsp_valid after 2 clocks with rsp_id=0, rsp_c=7.
2. All four valid continuously, rsp_ready=1 → grants 0,1,2,3,0,1… on consecutive cycles. Responses arrive in the same order with ids 0,1,2,3, no bubbles.
3. Extremes: a=-8,b=-8 → rsp_c=-16 (5'b10000); a=7,b=7 → 14; a=-8,b=7 → -1.
4. Backpressure: rsp_ready=0, req1 always valid → exactly 4 handshakes, then req_ready=0 and busy=1. Hold rsp_ready=1 for one cycle → one pop, then exactly one more issue. The FIFO never exceeds 4 entries.
5. Same-cycle pop and issue with credits=1 → credits stays 1 and issue proceeds.
6. Drop reset to 0 mid-stream with 2 ops in flight and 1 buffered → rsp_valid, req_ready, add_en low immediately. After release, credits=4 and the first grant with all valid goes to requester 0. No stale response appears.
